fp16_vadd_pipe: RTL

FP16_VADD_PIPE -- requirements
Module: fp16_vadd_pipe

---
 rtl/fp16_vadd_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fp16_vadd_pipe.sv
// fp16_vadd_pipe: LANES-wide, two-stage pipelined FP16 vector adder with valid/ready flow control.
// Optional feature macro VADD_SUB_EN adds the Op port (0 = A+B, 1 = A-B); without it the block only adds.
// Ports: Clk2 (clock), Rst (sync, active-high), In_valid/In_ready with A/B[/Op] in,
//        Sum/Overflow/Out_valid with Out_ready out, Ovf_sticky with its clear Clr_ovf.
module fp16_vadd_pipe #(
   parameter int LANES     = 4,
   parameter int STALL_OUT = 1
) (
   input  logic                Clk2,
   input  logic                Rst,
   input  logic                In_valid,
   output logic                In_ready,
   input  logic [16*LANES-1:0] A,
   input  logic [16*LANES-1:0] B,
`ifdef VADD_SUB_EN
   input  logic                Op,
`endif
   output logic [16*LANES-1:0] Sum,
   output logic [LANES-1:0]    Overflow,
   output logic                Out_valid,
   input  logic                Out_ready,
   output logic                Ovf_sticky,
   input  logic                Clr_ovf
);
   logic adv, sub, s1_valid_q, s2_valid_q, sticky_q;
`ifdef VADD_SUB_EN
   assign sub = Op;
`else
   assign sub = 1'b0;
`endif
   assign adv        = (STALL_OUT == 0) || !s2_valid_q || Out_ready;
   assign In_ready   = adv;
   assign Out_valid  = s2_valid_q;
   assign Ovf_sticky = sticky_q;
   function automatic logic [3:0] lzc14(input logic [13:0] v);
      lzc14 = 4'd14;
      for (int i = 0; i < 14; i++)
         if (v[i]) lzc14 = 4'(13 - i);
   endfunction
   always_ff @(posedge Clk2) begin
      if (Rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         if (adv) begin
            s1_valid_q <= In_valid;
            s2_valid_q <= s1_valid_q;
         end
         // a set in the same cycle as a clear wins
         sticky_q <= (s2_valid_q && Out_ready && |Overflow) || (sticky_q && !Clr_ovf);
      end
   end
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [15:0] a, b;
      logic        sa, sb, a_ge, eq, stk;
      logic [4:0]  ea, eb, exl, exs, d;
      logic [10:0] ml, ms;
      logic [13:0] ext, sh;
      logic        s1_sign_d, s1_inf_d, s1_sign_q, s1_inf_q;
      logic [4:0]  s1_exp_d, s1_exp_q;
      logic [14:0] s1_raw_d, s1_raw_q;
      logic [3:0]  lz;
      logic [4:0]  shn, exn, enc;
      logic [13:0] m;
      logic        rup, ovf_d, ovf_q;
      logic [14:0] r;
      logic [15:0] sum_d, sum_q;
      // Stage 1: denormals use exponent 1 with no hidden bit; the smaller operand is
      // aligned into {hidden, fraction, guard, round, sticky}.
      always_comb begin
         a         = A[16*k +: 16];
         b         = B[16*k +: 16];
         sa        = a[15];
         sb        = b[15] ^ sub;
         a_ge      = a[14:0] >= b[14:0];
         eq        = a[14:0] == b[14:0];
         ea        = a[14:10] | {4'd0, ~|a[14:10]};
         eb        = b[14:10] | {4'd0, ~|b[14:10]};
         exl       = a_ge ? ea : eb;
         exs       = a_ge ? eb : ea;
         ml        = a_ge ? {|a[14:10], a[9:0]} : {|b[14:10], b[9:0]};
         ms        = a_ge ? {|b[14:10], b[9:0]} : {|a[14:10], a[9:0]};
         d         = exl - exs;
         ext       = {ms, 3'b000};
         sh        = ext >> d;
         stk       = |(ext & ~(14'h3FFF << d));
         s1_raw_d  = (sa ^ sb) ? {1'b0, ml, 3'b000} - {1'b0, sh[13:1], sh[0] | stk}
                               : {1'b0, ml, 3'b000} + {1'b0, sh[13:1], sh[0] | stk};
         s1_exp_d  = exl;
         s1_inf_d  = &a[14:10] || &b[14:10];
         // an exact zero is negative only when both inputs are negative
         s1_sign_d = &a[14:10] ? sa : &b[14:10] ? sb : eq ? sa & sb : a_ge ? sa : sb;
      end
      // Stage 2: the left shift stops at exponent 1 so tiny results stay denormal;
      // adding the round-up into {exponent, fraction} carries straight into the exponent.
      always_comb begin
         lz    = lzc14(s1_raw_q[13:0]);
         shn   = ({1'b0, lz} < s1_exp_q) ? {1'b0, lz} : s1_exp_q - 5'd1;
         m     = s1_raw_q[14] ? {s1_raw_q[14:2], |s1_raw_q[1:0]} : s1_raw_q[13:0] << shn;
         exn   = s1_raw_q[14] ? s1_exp_q + 5'd1 : s1_exp_q - shn;
         enc   = m[13] ? exn : 5'd0;
         rup   = m[2] && (m[1] || m[0] || m[3]);
         r     = {enc, m[12:3]} + {14'd0, rup};
         ovf_d = s1_inf_q || &enc || &r[14:10];
         sum_d = ovf_d ? {s1_sign_q, 5'h1F, 10'h000} : {s1_sign_q, r};
      end
      always_ff @(posedge Clk2) begin
         if (adv && In_valid) begin
            s1_sign_q <= s1_sign_d;
            s1_inf_q  <= s1_inf_d;
            s1_exp_q  <= s1_exp_d;
            s1_raw_q  <= s1_raw_d;
         end
         if (Rst) begin
            sum_q <= 16'h0000;
            ovf_q <= 1'b0;
         end else if (adv && s1_valid_q) begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
         end
      end
      assign Sum[16*k +: 16] = sum_q;
      assign Overflow[k]     = ovf_q;
   end
endmodule
